cmd_stream_arbiter_2x32: RTL and testbench

- Two-master AXI-Stream arbiter that merges two 32-bit command sources onto the single command stream feeding the tone-config decoder (decoder sink can deassert tready for bubbles).
- Example sources: PS DMA and an on-fabric sequencer.
- Grants are transaction-locked: once a source wins, it owns the stream until it sends a commit-class command, so INDEX/GAIN writes from different masters never interleave before a COMMIT.
- A watchdog releases a stalled owner.

---
 rtl/cmd_stream_arbiter_2x32_pkg.sv | 25 ++
 rtl/cmd_stream_arbiter_2x32_slice.sv | 28 ++
 rtl/cmd_stream_arbiter_2x32.sv | 127 ++++++++++++
 tb/tb_cmd_stream_arbiter_2x32.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_stream_arbiter_2x32_pkg.sv
// Shared command opcodes and arbiter FSM encoding.
// Used by the command arbiter and the tone-config decoder.
package cmd_stream_arbiter_2x32_pkg;

  localparam logic [3:0] CMD_IDX         = 4'h1;
  localparam logic [3:0] CMD_GAIN        = 4'h2;
  localparam logic [3:0] CMD_IDX_COMMIT  = 4'h3;
  localparam logic [3:0] CMD_GAIN_COMMIT = 4'h4;
  localparam logic [3:0] CMD_SAFE        = 4'hC;
  localparam logic [3:0] CMD_COMMIT      = 4'hF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_GRANT,
    ST_LOCKED
  } arb_state_t;

  function automatic logic is_commit_class(input logic [3:0] cmd);
    return (cmd == CMD_IDX_COMMIT)  ||
           (cmd == CMD_GAIN_COMMIT) ||
           (cmd == CMD_SAFE)        ||
           (cmd == CMD_COMMIT);
  endfunction

endpackage

// File: rtl/cmd_stream_arbiter_2x32_slice.sv
// Single-entry valid/ready register slice (32-bit).
// Ports: in_* upstream beat, out_* registered beat.
module axis_reg_slice32 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready
);

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/cmd_stream_arbiter_2x32.sv
// Transaction-locked 2:1 command stream arbiter with watchdog.
// Ports: s0/s1 sources, m sink, owner/locked/timeout status.
module cmd_stream_arbiter_2x32
  import cmd_stream_arbiter_2x32_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned TOCNT_W     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [31:0]        s0_axis_tdata,
  input  logic               s0_axis_tvalid,
  output logic               s0_axis_tready,
  input  logic [31:0]        s1_axis_tdata,
  input  logic               s1_axis_tvalid,
  output logic               s1_axis_tready,
  output logic [31:0]        m_axis_tdata,
  output logic               m_axis_tvalid,
  input  logic               m_axis_tready,
  output logic               owner,
  output logic               locked,
  output logic               timeout_pulse,
  output logic [TOCNT_W-1:0] timeout_cnt
);

  localparam bit WD_EN = (TIMEOUT_CYC > 0);
  localparam int WD_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(TIMEOUT_CYC - 1);

  arb_state_t      state, state_n;
  logic            owner_n;
  logic            prio, prio_n;
  logic [WD_W-1:0] wd, wd_n;
  logic            to_evt;

  logic [31:0] sel_data;
  logic        sel_valid;
  logic        slice_ready;
  logic        owner_ready;
  logic        accept;
  logic        commit;
  logic        wd_hit;

  assign sel_data    = owner ? s1_axis_tdata : s0_axis_tdata;
  assign sel_valid   = owner ? s1_axis_tvalid : s0_axis_tvalid;
  assign owner_ready = (state == ST_LOCKED) & slice_ready;
  assign s0_axis_tready = owner_ready & ~owner;
  assign s1_axis_tready = owner_ready & owner;
  assign accept = owner_ready & sel_valid;
  assign commit = accept & is_commit_class(sel_data[31:28]);
  assign locked = (state == ST_LOCKED);

  // Backpressure keeps sel_valid high, so it never counts as idle.
  assign wd_hit = WD_EN && (state == ST_LOCKED) &&
                  !sel_valid && (wd == WD_TERM);

  axis_reg_slice32 u_slice (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (sel_data),
    .in_valid  (accept),
    .in_ready  (slice_ready),
    .out_data  (m_axis_tdata),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready)
  );

  always_comb begin
    state_n = state;
    owner_n = owner;
    prio_n  = prio;
    wd_n    = wd;
    to_evt  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (s0_axis_tvalid || s1_axis_tvalid) begin
          state_n = ST_GRANT;
          if (s0_axis_tvalid && s1_axis_tvalid)
            owner_n = prio;
          else
            owner_n = s1_axis_tvalid;
        end
      end
      ST_GRANT: begin
        state_n = ST_LOCKED;
        wd_n    = '0;
      end
      ST_LOCKED: begin
        if (commit) begin
          state_n = ST_IDLE;
          prio_n  = ~owner;
          wd_n    = '0;
        end else if (wd_hit) begin
          state_n = ST_IDLE;
          prio_n  = ~owner;
          wd_n    = '0;
          to_evt  = 1'b1;
        end else if (WD_EN && !sel_valid) begin
          wd_n = wd + WD_W'(1);
        end else begin
          wd_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      owner         <= 1'b0;
      prio          <= 1'b0;
      wd            <= '0;
      timeout_pulse <= 1'b0;
      timeout_cnt   <= '0;
    end else begin
      state         <= state_n;
      owner         <= owner_n;
      prio          <= prio_n;
      wd            <= wd_n;
      timeout_pulse <= to_evt;
      if (to_evt && (timeout_cnt != '1))
        timeout_cnt <= timeout_cnt + TOCNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cmd_stream_arbiter_2x32.sv
// Directed bench for cmd_stream_arbiter_2x32 with a cycle model.
// Drives inputs 1ns after posedge, compares on negedge.
module tb_cmd_stream_arbiter_2x32;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s0d = '0, s1d = '0;
  logic        s0v = 1'b0, s1v = 1'b0;
  logic        s0_rdy, s1_rdy;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic        owner, locked, to_pulse;
  logic [7:0]  to_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int pulses = 0;
  logic [31:0] out_log[$];
  logic [31:0] exp_q[$];

  cmd_stream_arbiter_2x32 #(.TIMEOUT_CYC(TO), .TOCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .s0_axis_tdata(s0d), .s0_axis_tvalid(s0v),
    .s0_axis_tready(s0_rdy),
    .s1_axis_tdata(s1d), .s1_axis_tvalid(s1v),
    .s1_axis_tready(s1_rdy),
    .m_axis_tdata(m_data), .m_axis_tvalid(m_valid),
    .m_axis_tready(m_ready),
    .owner(owner), .locked(locked),
    .timeout_pulse(to_pulse), .timeout_cnt(to_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  // Model: phase 0 idle, 1 grant, 2 locked.
  int          ph, idle;
  logic        own, pref, mv, pulse;
  logic [31:0] md;
  logic [7:0]  tocnt;

  initial forever begin
    logic ov, acc, cmt;
    logic [31:0] od;
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ph = 0; idle = 0; own = 0; pref = 0;
      mv = 0; md = '0; pulse = 0; tocnt = '0;
    end else begin
      ov  = own ? s1v : s0v;
      od  = own ? s1d : s0d;
      acc = (ph == 2) && ov && (!mv || m_ready);
      cmt = acc && (od[31:28] inside {4'h3, 4'h4, 4'hC, 4'hF});
      if (acc) begin
        mv = 1; md = od;
      end else if (m_ready) begin
        mv = 0;
      end
      pulse = 0;
      case (ph)
        0: if (s0v || s1v) begin
          own = (s0v && s1v) ? pref : s1v;
          ph = 1;
        end
        1: begin ph = 2; idle = 0; end
        default: begin
          if (cmt) begin
            ph = 0; pref = !own;
          end else if (ov) begin
            idle = 0;
          end else begin
            idle++;
            if (idle == TO) begin
              ph = 0; pulse = 1; pref = !own; idle = 0;
              if (tocnt != 8'hFF) tocnt++;
            end
          end
        end
      endcase
    end
  end

  initial forever begin
    @(negedge clk);
    chk("m_tvalid", {31'b0, m_valid}, {31'b0, mv});
    if (mv) chk("m_tdata", m_data, md);
    chk("s0_tready", {31'b0, s0_rdy},
        {31'b0, ph == 2 && !own && (!mv || m_ready)});
    chk("s1_tready", {31'b0, s1_rdy},
        {31'b0, ph == 2 && own && (!mv || m_ready)});
    chk("owner", {31'b0, owner}, {31'b0, own});
    chk("locked", {31'b0, locked}, {31'b0, ph == 2});
    chk("timeout_pulse", {31'b0, to_pulse}, {31'b0, pulse});
    chk("timeout_cnt", {24'b0, to_cnt}, {24'b0, tocnt});
  end

  initial forever begin
    @(posedge clk);
    cyc++;
    if (rst_n && m_valid && m_ready) out_log.push_back(m_data);
    if (rst_n && to_pulse) pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input bit src, input logic [31:0] d,
                      output int acc_cyc);
    bit done = 0;
    if (src) begin s1v = 1; s1d = d; end
    else begin s0v = 1; s0d = d; end
    acc_cyc = -1;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      done = src ? s1_rdy : s0_rdy;
      @(posedge clk);
      #1;
    end
    if (done) acc_cyc = cyc;
    chk("send_accepted", {31'b0, done}, 32'd1);
  endtask

  task automatic stop(input bit src);
    if (src) s1v = 0; else s0v = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick(2);
    rst_n = 1;
    out_log = {};
    pulses = 0;
  endtask

  task automatic chk_log(input string name);
    chk({name, "_len"}, out_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      chk(name, out_log[i], exp_q[i]);
  endtask

  initial begin
    int c0, c1, t;
    tick(1);
    do_reset();

    // Single source
    send(0, 32'h1000_0005, t);
    send(0, 32'h2000_1234, t);
    send(0, 32'hF000_0000, t);
    stop(0);
    tick(3);
    exp_q = {32'h1000_0005, 32'h2000_1234, 32'hF000_0000};
    chk_log("t1_out");
    chk("t1_locked", {31'b0, locked}, 32'd0);

    // Contention from reset
    do_reset();
    fork
      begin
        int a;
        send(0, 32'h1000_00A0, a); send(0, 32'h3000_00A1, a); stop(0);
      end
      begin
        int b;
        send(1, 32'h1000_00B0, b); send(1, 32'h3000_00B1, b); stop(1);
      end
    join
    tick(3);
    chk("t2_owner", {31'b0, owner}, 32'd1);
    fork
      begin
        int a;
        send(0, 32'h1000_00C0, a); send(0, 32'h4000_00C1, a); stop(0);
      end
      begin
        int b;
        send(1, 32'h1000_00D0, b); send(1, 32'hC000_00D1, b); stop(1);
      end
    join
    tick(3);
    exp_q = {32'h1000_00A0, 32'h3000_00A1, 32'h1000_00B0,
             32'h3000_00B1, 32'h1000_00C0, 32'h4000_00C1,
             32'h1000_00D0, 32'hC000_00D1};
    chk_log("t2_out");

    // s1 blocked mid-transaction
    do_reset();
    fork
      begin
        int a;
        send(0, 32'h1000_0001, a); send(0, 32'h2000_0003, a);
        send(0, 32'hF000_0000, c0); stop(0);
      end
      begin
        int b;
        tick(4);
        send(1, 32'h1800_0002, c1); send(1, 32'h3000_0004, b);
        stop(1);
      end
    join
    tick(3);
    chk("t3_gap_ge3", {31'b0, (c1 - c0) >= 3}, 32'd1);
    exp_q = {32'h1000_0001, 32'h2000_0003, 32'hF000_0000,
             32'h1800_0002, 32'h3000_0004};
    chk_log("t3_out");

    // Backpressure for 5 cycles
    do_reset();
    m_ready = 0;
    fork
      begin
        int a;
        send(0, 32'h1000_0010, a); send(0, 32'h2000_0011, a);
        send(0, 32'hF000_0012, a); stop(0);
      end
      begin
        bit seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
          @(negedge clk); seen = m_valid;
        end
        chk("t4_buffered", {31'b0, seen}, 32'd1);
        repeat (5) begin
          @(negedge clk);
          chk("t4_hold_data", m_data, 32'h1000_0010);
          chk("t4_hold_rdy", {31'b0, s0_rdy}, 32'd0);
        end
        tick(1);
        m_ready = 1;
      end
    join
    tick(3);
    exp_q = {32'h1000_0010, 32'h2000_0011, 32'hF000_0012};
    chk_log("t4_out");

    // Watchdog
    do_reset();
    fork
      begin
        int b;
        send(1, 32'h2800_0100, b); stop(1);
      end
      begin
        int a;
        tick(3);
        send(0, 32'h1000_0200, a); stop(0);
      end
    join
    chk("t5_cnt1", {24'b0, to_cnt}, 32'd1);
    chk("t5_owner", {31'b0, owner}, 32'd0);
    tick(20);
    for (int i = 0; i < 256; i++) begin
      send(0, 32'h1000_0000 | i, t);
      stop(0);
      tick(20);
    end
    chk("t5_cnt_sat", {24'b0, to_cnt}, 32'd255);
    chk("t5_pulses", pulses, 32'd258);

    // Async reset mid-transaction
    out_log = {};
    m_ready = 0;
    s0v = 1; s0d = 32'h1000_0300;
    begin
      bit seen = 0;
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk); seen = m_valid;
      end
      chk("t6_buffered", {31'b0, seen}, 32'd1);
    end
    tick(1);
    rst_n = 0;
    #1;
    chk("t6_rst_valid", {31'b0, m_valid}, 32'd0);
    chk("t6_rst_data", m_data, 32'd0);
    chk("t6_rst_locked", {31'b0, locked}, 32'd0);
    chk("t6_rst_rdy", {30'b0, s0_rdy, s1_rdy}, 32'd0);
    chk("t6_rst_cnt", {24'b0, to_cnt}, 32'd0);
    s0v = 0;
    tick(2);
    rst_n = 1;
    out_log = {};
    m_ready = 1;
    fork
      begin
        int a;
        send(0, 32'h3000_0301, a); stop(0);
      end
      begin
        int b;
        send(1, 32'h3000_0302, b); stop(1);
      end
    join
    tick(3);
    exp_q = {32'h3000_0301, 32'h3000_0302};
    chk_log("t6_out");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
